// File: rtl/servo_adc_pkg.sv
// Shared definitions for the comparator servo: mode encodings, the LFSR seed
// and the dither LFSR step function.
package servo_adc_pkg;

    typedef enum logic [1:0] {
        MODE_TRACK = 2'b00,
        MODE_SWEEP = 2'b01,
        MODE_HOLD  = 2'b10
    } mode_e;

    localparam logic [31:0] LFSR_SEED = 32'hDEADBEEF;

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return {l[31] ^ l[30] ^ l[10] ^ l[0], l[31:1]};
    endfunction

endpackage

// File: rtl/servo_adc_window_popcount.sv
// Synchronises the comparator, keeps a WINDOW_BITS-deep history of hits
// (comparator low) and an exact running popcount of that history.
module window_popcount #(
    parameter int WINDOW_BITS = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         comp_in,
    output logic [$clog2(WINDOW_BITS):0] window_count
);

    localparam int CW = $clog2(WINDOW_BITS) + 1;

    logic                   sync1_q;
    logic                   sync2_q;
    logic                   hit;
    logic                   evicted;
    logic [WINDOW_BITS-1:0] shift_q;
    logic [WINDOW_BITS-1:0] shift_d;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;

    assign hit     = ~sync2_q;
    assign evicted = shift_q[WINDOW_BITS-1];

    assign shift_d[0] = hit;
    for (genvar gi = 1; gi < WINDOW_BITS; gi++) begin : g_shift
        assign shift_d[gi] = shift_q[gi-1];
    end

    // Add the incoming bit and drop the evicted one on the same edge, so the
    // count always equals the popcount of shift_q and can never wrap.
    assign count_d = count_q + CW'(hit) - CW'(evicted);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Synchroniser idles high so reset never injects phantom hits.
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            shift_q <= '0;
            count_q <= '0;
        end else begin
            sync1_q <= comp_in;
            sync2_q <= sync1_q;
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    assign window_count = count_q;

endmodule

// File: rtl/servo_adc.sv
// Comparator servo: steps a DAC level toward 50 % comparator-low occupancy,
// with TRACK/SWEEP/HOLD modes, lock detection and an LFSR-dithered PWM output.
module servo_adc
    import servo_adc_pkg::*;
#(
    parameter int WINDOW_BITS = 1024,
    parameter int DAC_BITS    = 16,
    parameter int UPDATE_LOG2 = 21,
    parameter int DEADBAND    = 20,
    parameter int GAIN_SHIFT  = 4,
    parameter int LOCK_COUNT  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         comp_in,
    input  logic [1:0]                   mode,
    output logic                         dac_out,
    output logic [DAC_BITS-1:0]          level,
    output logic [$clog2(WINDOW_BITS):0] window_count,
    output logic                         locked,
    output logic [DAC_BITS-1:0]          sample,
    output logic                         sample_valid
);

    localparam int CW = $clog2(WINDOW_BITS) + 1;
    localparam int EW = CW + 1;
    localparam int SW = ((DAC_BITS > EW) ? DAC_BITS : EW) + 1;
    localparam int LW = $clog2(LOCK_COUNT + 1);

    localparam logic signed [EW-1:0] HALF_WINDOW = EW'(WINDOW_BITS / 2);
    localparam logic [DAC_BITS-1:0]  LEVEL_MID   = DAC_BITS'(1) << (DAC_BITS - 1);
    localparam logic [DAC_BITS-1:0]  LEVEL_MAX   = '1;
    localparam logic [LW-1:0]        LOCK_FULL   = LW'(LOCK_COUNT);

    logic [UPDATE_LOG2-1:0] tick_cnt_q;
    logic                   tick;
    logic [DAC_BITS-1:0]    level_q, level_d;
    logic [LW-1:0]          lock_cnt_q, lock_cnt_d;
    logic                   locked_q, locked_d;
    logic [DAC_BITS-1:0]    sample_q, sample_d;
    logic                   sample_valid_q, sample_valid_d;
    logic [31:0]            lfsr_q;
    logic                   dac_q;

    logic signed [EW-1:0]   err;
    logic [EW-1:0]          err_mag;
    logic [EW-1:0]          step;
    logic [SW-1:0]          up_sum;
    logic [DAC_BITS-1:0]    level_up;
    logic [DAC_BITS-1:0]    level_dn;
    logic                   in_band;

    window_popcount #(
        .WINDOW_BITS (WINDOW_BITS)
    ) u_window (
        .clk          (clk),
        .rst_n        (rst_n),
        .comp_in      (comp_in),
        .window_count (window_count)
    );

    assign tick = &tick_cnt_q;

    assign err     = $signed({1'b0, window_count}) - HALF_WINDOW;
    assign in_band = (err <= DEADBAND) && (err >= -DEADBAND);
    assign err_mag = err[EW-1] ? EW'(-err) : EW'(err);
    // Gain applies to the magnitude first, then the +1 guarantees progress.
    assign step    = (err_mag >> GAIN_SHIFT) + EW'(1);

    // Saturating steps computed in a width wide enough for both operands.
    assign up_sum   = SW'(level_q) + SW'(step);
    assign level_up = (up_sum > SW'(LEVEL_MAX)) ? LEVEL_MAX : up_sum[DAC_BITS-1:0];
    assign level_dn = (SW'(step) > SW'(level_q)) ? '0 : level_q - DAC_BITS'(step);

    always_comb begin
        level_d        = level_q;
        lock_cnt_d     = lock_cnt_q;
        locked_d       = locked_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        if (tick) begin
            case (mode)
                MODE_TRACK: begin
                    if (err > DEADBAND) begin
                        level_d = level_up;
                    end else if (err < -DEADBAND) begin
                        level_d = level_dn;
                    end
                    if (in_band) begin
                        lock_cnt_d = (lock_cnt_q == LOCK_FULL) ? lock_cnt_q : lock_cnt_q + LW'(1);
                    end else begin
                        lock_cnt_d = '0;
                    end
                    locked_d = (lock_cnt_d == LOCK_FULL);
                end
                MODE_SWEEP: begin
                    level_d    = level_q + DAC_BITS'(1);
                    lock_cnt_d = '0;
                    locked_d   = 1'b0;
                end
                default: begin
                    // HOLD and the reserved encoding freeze the loop.
                end
            endcase
            if (locked_d) begin
                sample_valid_d = 1'b1;
                sample_d       = level_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q     <= '0;
            level_q        <= LEVEL_MID;
            lock_cnt_q     <= '0;
            locked_q       <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            lfsr_q         <= LFSR_SEED;
            dac_q          <= 1'b0;
        end else begin
            tick_cnt_q     <= tick_cnt_q + UPDATE_LOG2'(1);
            level_q        <= level_d;
            lock_cnt_q     <= lock_cnt_d;
            locked_q       <= locked_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            lfsr_q         <= lfsr_next(lfsr_q);
            dac_q          <= (lfsr_q[DAC_BITS-1:0] < level_q);
        end
    end

    assign dac_out      = dac_q;
    assign level        = level_q;
    assign locked       = locked_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_servo_adc.sv
// Scoreboard bench for servo_adc with small parameters: stimulus pushes the
// expected per-tick level/lock and sample pulses; a monitor pops and compares.
module tb_servo_adc;

    localparam int WB = 16;
    localparam int DB = 8;
    localparam int UL = 4;
    localparam int TP = 1 << UL;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       comp_in;
    logic [1:0] mode;
    logic       dac_out;
    logic [7:0] level;
    logic [4:0] window_count;
    logic       locked;
    logic [7:0] sample;
    logic       sample_valid;

    servo_adc #(
        .WINDOW_BITS (WB),
        .DAC_BITS    (DB),
        .UPDATE_LOG2 (UL),
        .DEADBAND    (2),
        .GAIN_SHIFT  (1),
        .LOCK_COUNT  (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .comp_in      (comp_in),
        .mode         (mode),
        .dac_out      (dac_out),
        .level        (level),
        .window_count (window_count),
        .locked       (locked),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    typedef struct { int tick; int lvl; bit lk; } tick_exp_t;
    typedef struct { int tick; int val; } samp_exp_t;

    tick_exp_t tq[$];
    samp_exp_t sq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rec_run = 2;
    bit toggle_en = 1'b0;
    bit rec0 [1:32];
    bit rec1 [1:32];
    bit model [1:32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_tick(input int t, input int lvl, input bit lk);
        tick_exp_t e;
        e.tick = t; e.lvl = lvl; e.lk = lk;
        tq.push_back(e);
    endtask

    task automatic push_sample(input int t, input int v);
        samp_exp_t s;
        s.tick = t; s.val = v;
        sq.push_back(s);
    endtask

    task automatic go_to_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_level", level, 128);
        check("rst_window_count", window_count, 0);
        check("rst_locked", locked, 0);
        check("rst_sample", sample, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_dac_out", dac_out, 0);
        rst_n = 1'b1;
    endtask

    // Comparator toggles every clock when enabled.
    initial forever begin
        @(negedge clk);
        if (toggle_en) comp_in = ~comp_in;
    end

    // Monitor: cycle count since reset, dac recording, tick and sample checks.
    initial begin
        tick_exp_t e;
        samp_exp_t s;
        int n;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) cyc = 0;
            else cyc++;
            if (rst_n && cyc >= 1 && cyc <= 32) begin
                if (rec_run == 0) rec0[cyc] = dac_out;
                else if (rec_run == 1) rec1[cyc] = dac_out;
            end
            if (rst_n && cyc > 0 && cyc % TP == 0) begin
                n = cyc / TP;
                while (tq.size() > 0 && tq[0].tick < n) begin
                    e = tq.pop_front();
                    checks++; errors++;
                    $display("FAIL tick_missed: got tick %0d expected tick %0d", n, e.tick);
                end
                if (tq.size() > 0 && tq[0].tick == n) begin
                    e = tq.pop_front();
                    $display("tick %0d: level=%0d locked=%0d (expect %0d/%0d)", n, level, locked, e.lvl, e.lk);
                    check("tick_level", level, e.lvl);
                    check("tick_locked", locked, e.lk);
                end
            end
            if (sample_valid) begin
                if (sq.size() > 0 && cyc % TP == 0 && sq[0].tick == cyc / TP) begin
                    s = sq.pop_front();
                    $display("sample at tick %0d: %0d (expect %0d)", s.tick, sample, s.val);
                    check("sample_value", sample, s.val);
                end else begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: got pulse at cycle %0d expected none", cyc);
                end
            end else if (rst_n && cyc > 0 && cyc % TP == 0 && sq.size() > 0 && sq[0].tick == cyc / TP) begin
                s = sq.pop_front();
                checks++; errors++;
                $display("FAIL missing_valid: got no pulse expected one at tick %0d", s.tick);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] l;
        int lvl;

        l = 32'hDEADBEEF;
        for (int k = 1; k <= 32; k++) begin
            model[k] = (l[7:0] < 8'd128);
            l = {l[31] ^ l[30] ^ l[10] ^ l[0], l[31:1]};
        end

        rst_n = 1'b0; comp_in = 1'b0; mode = 2'b10;

        // Hits every sample; HOLD until the window fills, then TRACK to saturation.
        rec_run = 0;
        do_reset();
        push_tick(1, 128, 0);
        lvl = 128;
        for (int t = 2; t <= 28; t++) begin
            lvl = (lvl + 5 > 255) ? 255 : lvl + 5;
            push_tick(t, lvl, 0);
        end
        go_to_edge(2);  check("wc_edge2", window_count, 0);
        go_to_edge(3);  check("wc_edge3", window_count, 1);
        go_to_edge(18); check("wc_edge18", window_count, 16);
        mode = 2'b00;
        go_to_edge(32);
        for (int k = 1; k <= 32; k++) check("dac_run1", rec0[k], model[k]);
        rec_run = 2;
        go_to_edge(TP * 28 + 1);

        // No hits: TRACK descends to 0.
        comp_in = 1'b1; mode = 2'b00;
        do_reset();
        lvl = 128;
        for (int t = 1; t <= 27; t++) begin
            lvl = (lvl < 5) ? 0 : lvl - 5;
            push_tick(t, lvl, 0);
        end
        go_to_edge(20); check("wc_empty", window_count, 0);
        go_to_edge(TP * 27 + 1);

        // 50 % occupancy locks; HOLD freezes; TRACK with full window unlocks.
        comp_in = 1'b0; mode = 2'b10; toggle_en = 1'b1;
        do_reset();
        push_tick(1, 128, 0);
        go_to_edge(18);
        mode = 2'b00;
        push_tick(2, 128, 0); push_tick(3, 128, 0);
        for (int t = 4; t <= 6; t++) begin
            push_tick(t, 128, 1); push_sample(t, 128);
        end
        go_to_edge(20); check("wc_half", (window_count >= 7 && window_count <= 9), 1);
        go_to_edge(96);
        mode = 2'b10; toggle_en = 1'b0; comp_in = 1'b0;
        for (int t = 7; t <= 9; t++) begin
            push_tick(t, 128, 1); push_sample(t, 128);
        end
        go_to_edge(144);
        check("wc_full_hold", window_count, 16);
        mode = 2'b00;
        push_tick(10, 133, 0);
        go_to_edge(TP * 10 + 1);

        // Lock, then SWEEP through the wrap, then reset mid-sweep.
        comp_in = 1'b0; mode = 2'b10; toggle_en = 1'b1;
        do_reset();
        push_tick(1, 128, 0);
        go_to_edge(18);
        mode = 2'b00;
        push_tick(2, 128, 0); push_tick(3, 128, 0);
        push_tick(4, 128, 1); push_sample(4, 128);
        go_to_edge(66);
        mode = 2'b01;
        lvl = 128;
        for (int t = 5; t <= 133; t++) begin
            lvl = (lvl + 1) % 256;
            push_tick(t, lvl, 0);
        end
        go_to_edge(TP * 133 + 3);
        mode = 2'b10; toggle_en = 1'b0; comp_in = 1'b0; rec_run = 1;
        do_reset();
        go_to_edge(3); check("wc_edge3_rerun", window_count, 1);
        go_to_edge(32);
        for (int k = 1; k <= 32; k++) check("dac_run2", rec1[k], model[k]);
        for (int k = 1; k <= 32; k++) check("dac_repeat", rec1[k], rec0[k]);
        rec_run = 2;

        go_to_edge(40);
        check("tick_queue_drained", tq.size(), 0);
        check("sample_queue_drained", sq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_adc.md
# servo_adc

Parametrised successor to the single-channel comparator servo. It closes a loop around an external comparator (ILVDS input against an RC-filtered PWM threshold): it counts comparator-low samples over a sliding window and steps a DAC level toward 50 % occupancy. The DAC level drives an LFSR-dithered 1-bit PWM threshold pin. New in this block: TRACK/SWEEP/HOLD modes, exact window arithmetic, saturating signed gain, lock detection, and a sample/valid output for downstream logging.

## Interface
- WINDOW_BITS, 1024: sliding-window length in samples; power of two, ≥ 4.
- DAC_BITS, 16: DAC level width; 1..32.
- UPDATE_LOG2, 21: the servo updates once every 2^UPDATE_LOG2 clocks.
- DEADBAND, 20: allowed |error| around WINDOW_BITS/2 with no correction.
- GAIN_SHIFT, 4: the magnitude of the error is right-shifted by this amount to form the step.
- LOCK_COUNT, 8: number of consecutive in-deadband ticks required to assert `locked`.
- clk  in  1  system clock (PLL output).
- rst_n  in  1  synchronous, active-low reset.
- comp_in  in  1  raw comparator output, asynchronous; a low value counts as a hit.
- mode  in  2  00 TRACK, 01 SWEEP, 10 HOLD, 11 treated as HOLD.
- dac_out  out  1  PWM threshold pin, registered.
- level  out  DAC_BITS  current DAC level.
- window_count  out  $clog2(WINDOW_BITS)+1  hits in the current window, range 0..WINDOW_BITS.
- locked  out  1  loop is locked.
- sample  out  DAC_BITS  level captured when `sample_valid` pulses.
- sample_valid  out  1  one-cycle strobe.

## Operation
- Reset values (rst_n low at an edge): `level` = 1<<(DAC_BITS-1). The window shift register, `window_count`, tick counter, lock counter, `locked`, `sample`, `sample_valid` and `dac_out` all reset to 0. The LFSR reseeds to 32'hDEADBEEF. A reset asserted mid-operation behaves identically.
- Input path: `comp_in` passes through a 2-flop synchroniser. Its inverse (the hit bit) shifts into a WINDOW_BITS shift register. On the same edge, `window_count` <= `window_count` + new_bit − evicted MSB. This keeps `window_count` exactly equal to the register popcount and never wrapping.
- Tick: a free-running UPDATE_LOG2-bit counter; tick is asserted when the counter is all ones. `mode` is sampled only on tick.
- Error: e = `window_count` − WINDOW_BITS/2, signed, $clog2(WINDOW_BITS)+2 bits.
- TRACK on tick:
  - e > DEADBAND: `level` += 1 + (e>>GAIN_SHIFT), saturating at 2^DAC_BITS−1.
  - e < −DEADBAND: `level` −= 1 + ((−e)>>GAIN_SHIFT), saturating at 0.
  - Otherwise `level` is unchanged.
  - The shift is applied to the magnitude before the +1; this is explicit precedence.
- Lock, TRACK only:
  - In-deadband tick: lock counter increments, saturating at LOCK_COUNT.
  - Out-of-deadband tick: lock counter clears.
  - `locked` = (counter == LOCK_COUNT) and updates on the tick edge.
- SWEEP on tick: `level` += 1, wrapping 2^DAC_BITS−1 → 0. The lock counter and `locked` are cleared.
- HOLD on tick: `level`, the lock counter and `locked` are frozen.
- Valid: on every tick edge where `locked` is 1 after the update (TRACK or HOLD), `sample_valid` = 1 and `sample` = the new `level`. `sample_valid` is 0 on all other cycles. `sample` holds its value between pulses.
- DAC: 32-bit LFSR with next value {l[31]^l[30]^l[10]^l[0], l[31:1]}, advancing every clock. `dac_out` <= (l[DAC_BITS-1:0] < `level`).

## Timing
- With `comp_in` held low from reset release, `window_count` reaches 1 at edge 3 and WINDOW_BITS at edge WINDOW_BITS+2.
- The first tick occurs at edge 2^UPDATE_LOG2 after reset release, then every 2^UPDATE_LOG2 edges.
- `level`, `locked`, `sample` and `sample_valid` all update on the tick edge itself.
- `dac_out` reflects `level` one clock later.
- A mode change between ticks has no effect until the next tick.

## Structure
- Shared package/include `servo_adc_pkg`: mode encodings (MODE_TRACK, MODE_SWEEP, MODE_HOLD) and LFSR_SEED = 32'hDEADBEEF.
- Sub-module `window_popcount` (parameter WINDOW_BITS): synchroniser, shift register and exact running count.
- LFSR and servo FSM stay inline.

## Test plan
All scenarios use WINDOW_BITS=16, DAC_BITS=8, UPDATE_LOG2=4, DEADBAND=2, GAIN_SHIFT=1, LOCK_COUNT=3.
- `comp_in`=0, TRACK: `window_count`=16 at edge 18. The next tick gives e=8, so `level` goes 128 → 133. `level` then rises by 5 per tick and saturates at 255 without wrapping; `locked`=0.
- `comp_in`=1, TRACK: `window_count`=0, e=−8. `level` falls by 5 per tick and saturates at 0.
- `comp_in` toggling every clock, TRACK: `window_count` settles in 7..9, so `level` stays at 128. `locked`=1 on the 3rd in-deadband tick; from then on, `sample_valid` pulses once per tick with `sample`=128.
- SWEEP from `level`=254: the following ticks give 255 then 0. `locked` clears on the first SWEEP tick and `sample_valid` is never asserted.
- Locked, then HOLD, then `comp_in` forced to 0: `level` and `locked` stay frozen and valid keeps pulsing. Returning to TRACK, the first tick clears `locked` and steps `level` by +5.
- `rst_n` low for one cycle mid-sweep: the next edge restores all reset values, and the `dac_out` sequence repeats exactly the post-reset sequence of the first run.
